clear_sequencer: RTL and testbench

Generates the active-low clear strobes (`clearb`) that drive the team's clearable flip-flops and registers. It debounces a raw clear request, holds all `clearb` outputs low for a programmed interval, then releases them one at a time in a fixed order with a programmed stagger. It runs the same sequence automatically after its own reset, so downstream `clearb` consumers always see a clean, ordered power-on clear.

---
 rtl/clear_seq_pkg.sv | 16 +
 rtl/clear_req_debounce.sv | 39 +++
 rtl/clear_sequencer.sv | 133 +++++++++++++
 tb/tb_clear_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clear_seq_pkg.sv
// Shared types and width helpers for the clear strobe sequencer.
package clear_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StRelease,
        StWaitLow
    } clr_state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return int'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/clear_req_debounce.sv
// Debounces the raw clear request; trigger fires on the DEBOUNCE-th consecutive high sample.
module clear_req_debounce
    import clear_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clock,
    input  logic clear,
    input  logic req_in,
    output logic trigger
);

    localparam int unsigned DW = cnt_width(DEBOUNCE);
    localparam logic [DW-1:0] DbMax  = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DbLast = DW'(DEBOUNCE - 1);

    logic [DW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!req_in) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DbMax) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end

    // Saturation at DEBOUNCE keeps a held request from firing more than once.
    assign trigger = req_in && (db_cnt_q == DbLast);

endmodule

// File: rtl/clear_sequencer.sv
// Generates ordered active-low clear strobes: hold all low, then release bit 0 upward
// with a fixed stagger. Runs automatically out of reset and on each debounced request.
module clear_sequencer
    import clear_seq_pkg::*;
#(
    parameter int unsigned N_OUT       = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned DEBOUNCE    = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_in,
    output logic [N_OUT-1:0] clearb_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    localparam int unsigned SW = cnt_width(STAGGER);
    localparam int unsigned IW = cnt_width(N_OUT);

    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] StgLast  = SW'(STAGGER - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(N_OUT - 1);

    clr_state_t       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SW-1:0]    stg_q, stg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] clearb_q, clearb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trigger;

    clear_req_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clock  (clock),
        .clear  (clear),
        .req_in (req_in),
        .trigger(trigger)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        stg_d    = stg_q;
        idx_d    = idx_q;
        clearb_d = clearb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d  = StAssert;
                    clearb_d = '0;
                    busy_d   = 1'b1;
                    hold_d   = '0;
                end
            end
            StAssert: begin
                if (hold_q == HoldLast) begin
                    clearb_d[0] = 1'b1;
                    if (N_OUT == 1) begin
                        state_d = StWaitLow;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRelease;
                        idx_d   = IW'(1);
                        stg_d   = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRelease: begin
                if (stg_q == StgLast) begin
                    stg_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int unsigned i = 0; i < N_OUT; i++) begin
                        if (IW'(i) == idx_q) begin
                            clearb_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IdxLast) begin
                        state_d = StWaitLow;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            StWaitLow: begin
                if (!req_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset lands in StAssert so the power-on clear runs without a request.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= StAssert;
            hold_q   <= '0;
            stg_q    <= '0;
            idx_q    <= '0;
            clearb_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            stg_q    <= stg_d;
            idx_q    <= idx_d;
            clearb_q <= clearb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign clearb_out = clearb_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_clear_sequencer.sv
// Bench for clear_sequencer: default-parameter instance plus a minimal corner instance.
module tb_clear_sequencer;

    localparam int Hold = 8;
    localparam int Stg  = 2;
    localparam int Last = Hold + 3 * Stg;

    typedef struct {
        string      name;
        logic       clr;
        logic       req;
        logic [3:0] cb;
        logic       busy;
        logic       done;
        logic       clr_c;
        logic       req_c;
        logic       cb_c;
        logic       busy_c;
        logic       done_c;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       req_in = 1'b0;
    logic [3:0] clearb_out;
    logic       busy, done;
    logic       clear_c = 1'b1;
    logic       req_c = 1'b0;
    logic [0:0] clearb_c;
    logic       busy_c, done_c;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    clear_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .req_in    (req_in),
        .clearb_out(clearb_out),
        .busy      (busy),
        .done      (done)
    );

    clear_sequencer #(
        .N_OUT      (1),
        .HOLD_CYCLES(1),
        .STAGGER    (1),
        .DEBOUNCE   (1)
    ) dut_c (
        .clock     (clock),
        .clear     (clear_c),
        .req_in    (req_c),
        .clearb_out(clearb_c),
        .busy      (busy_c),
        .done      (done_c)
    );

    // Expected strobes k edges after the edge that entered the hold phase.
    function automatic logic [3:0] cb_after(input int k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (k >= Hold + i * Stg);
        return r;
    endfunction

    task automatic push_main(input string nm, input logic clr, input logic req,
                             input logic [3:0] cb, input logic dn);
        vec_t v;
        v.name = nm; v.clr = clr; v.req = req; v.cb = cb; v.busy = (cb != 4'hf); v.done = dn;
        v.clr_c = 1'b1; v.req_c = 1'b0; v.cb_c = 1'b0; v.busy_c = 1'b1; v.done_c = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic push_corner(input string nm, input logic clr, input logic req,
                               input logic cb, input logic dn);
        vec_t v;
        v.name = nm; v.clr = 1'b0; v.req = 1'b0; v.cb = 4'hf; v.busy = 1'b0; v.done = 1'b0;
        v.clr_c = clr; v.req_c = req; v.cb_c = cb; v.busy_c = ~cb; v.done_c = dn;
        vecs.push_back(v);
    endtask

    task automatic gen_seq(input string nm, input int kmax, input int req_lo, input int req_hi);
        for (int k = 1; k <= kmax; k++) begin
            push_main(nm, 1'b0, (k >= req_lo && k <= req_hi), cb_after(k), k == Last);
        end
    endtask

    task automatic trigger_main(input string nm);
        push_main(nm, 1'b0, 1'b1, 4'hf, 1'b0);
        push_main(nm, 1'b0, 1'b1, 4'hf, 1'b0);
        push_main(nm, 1'b0, 1'b1, 4'h0, 1'b0);
    endtask

    task automatic chk(input string nm, input string field, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    initial begin
        forever begin
            vec_t e;
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "clearb", clearb_out, e.cb);
                chk(e.name, "busy", 4'(busy), 4'(e.busy));
                chk(e.name, "done", 4'(done), 4'(e.done));
                chk(e.name, "c_clearb", 4'(clearb_c), 4'(e.cb_c));
                chk(e.name, "c_busy", 4'(busy_c), 4'(e.busy_c));
                chk(e.name, "c_done", 4'(done_c), 4'(e.done_c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on clear with defaults.
        push_main("reset", 1'b1, 1'b0, 4'h0, 1'b0);
        push_main("reset", 1'b1, 1'b0, 4'h0, 1'b0);
        gen_seq("por", Last, 0, -1);
        push_main("por_idle", 1'b0, 1'b0, 4'hf, 1'b0);
        push_main("por_idle", 1'b0, 1'b0, 4'hf, 1'b0);

        // Request held high for 40 cycles: one sequence, then parked waiting for low.
        trigger_main("req");
        gen_seq("req", Last, 1, Last);
        for (int i = 0; i < 40 - 3 - Last; i++) push_main("req_wait", 1'b0, 1'b1, 4'hf, 1'b0);
        push_main("req_drop", 1'b0, 1'b0, 4'hf, 1'b0);
        trigger_main("req2");
        gen_seq("req2", Last, 0, -1);
        push_main("req2_idle", 1'b0, 1'b0, 4'hf, 1'b0);

        // Glitches shorter than the debounce window.
        push_main("glitch", 1'b0, 1'b1, 4'hf, 1'b0);
        push_main("glitch", 1'b0, 1'b1, 4'hf, 1'b0);
        push_main("glitch", 1'b0, 1'b0, 4'hf, 1'b0);
        push_main("glitch", 1'b0, 1'b1, 4'hf, 1'b0);
        push_main("glitch", 1'b0, 1'b1, 4'hf, 1'b0);
        push_main("glitch", 1'b0, 1'b0, 4'hf, 1'b0);
        push_main("glitch", 1'b0, 1'b0, 4'hf, 1'b0);

        // Full debounced request during the release phase is ignored.
        trigger_main("retrig");
        gen_seq("retrig", Last, Hold + 1, Hold + 3);
        push_main("retrig_idle", 1'b0, 1'b0, 4'hf, 1'b0);

        // Reset mid-release restarts the whole sequence.
        trigger_main("midrst");
        gen_seq("midrst", Hold + Stg, 0, -1);
        push_main("midrst_clr", 1'b1, 1'b0, 4'h0, 1'b0);
        push_main("midrst_clr", 1'b1, 1'b0, 4'h0, 1'b0);
        gen_seq("midrst_por", Last, 0, -1);
        push_main("midrst_idle", 1'b0, 1'b0, 4'hf, 1'b0);

        // Single-output, minimum-timing instance.
        push_corner("c_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        push_corner("c_por", 1'b0, 1'b0, 1'b1, 1'b1);
        push_corner("c_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        push_corner("c_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        push_corner("c_req", 1'b0, 1'b1, 1'b0, 1'b0);
        push_corner("c_rel", 1'b0, 1'b0, 1'b1, 1'b1);
        push_corner("c_idle2", 1'b0, 1'b0, 1'b1, 1'b0);
        push_corner("c_held", 1'b0, 1'b1, 1'b0, 1'b0);
        push_corner("c_held", 1'b0, 1'b1, 1'b1, 1'b1);
        push_corner("c_held", 1'b0, 1'b1, 1'b1, 1'b0);
        push_corner("c_held", 1'b0, 1'b1, 1'b1, 1'b0);
        push_corner("c_drop", 1'b0, 1'b0, 1'b1, 1'b0);
        push_corner("c_drop", 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            clear   = vecs[i].clr;
            req_in  = vecs[i].req;
            clear_c = vecs[i].clr_c;
            req_c   = vecs[i].req_c;
            sb.push_back(vecs[i]);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
